// File: rtl/bist_pattern_engine.sv
// BIST pattern engine: drives LFSR or counter patterns into a circuit under test
// and compacts its responses into a MISR signature for comparison against a golden value.
module bist_pattern_engine #(
    parameter int unsigned       PAT_W     = 4,
    parameter int unsigned       RESP_W    = 4,
    parameter int unsigned       NUM_PAT   = 15,
    parameter logic [PAT_W-1:0]  LFSR_TAPS = PAT_W'(4'b1100),
    parameter logic [PAT_W-1:0]  LFSR_SEED = PAT_W'(4'b0001),
    parameter logic [RESP_W-1:0] MISR_TAPS = RESP_W'(4'b1100)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [RESP_W-1:0] golden,
    output logic [PAT_W-1:0]  pat_out,
    input  logic [RESP_W-1:0] resp_in,
    output logic              busy,
    output logic              done,
    output logic [RESP_W-1:0] signature,
    output logic              pass
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [15:0] LAST_IDX = 16'(NUM_PAT - 1);

    state_t      state;
    state_t      state_next;
    logic        load;
    logic        capture;
    logic        mode_q;
    logic [15:0] idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        capture    = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                capture = 1'b1;
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Pattern and signature advance together once per RUN cycle; both hold in IDLE/DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_out   <= '0;
            signature <= '0;
            idx       <= '0;
            mode_q    <= 1'b0;
        end else if (load) begin
            mode_q    <= mode;
            pat_out   <= mode ? '0 : LFSR_SEED;
            signature <= '0;
            idx       <= '0;
        end else if (capture) begin
            signature <= {signature[RESP_W-2:0], ^(signature & MISR_TAPS)} ^ resp_in;
            if (mode_q) begin
                pat_out <= pat_out + PAT_W'(1);
            end else begin
                pat_out <= {pat_out[PAT_W-2:0], ^(pat_out & LFSR_TAPS)};
            end
            idx <= idx + 16'd1;
        end
    end

    assign pass = (state == DONE) && (signature == golden);

endmodule

// File: doc/bist_pattern_engine.md
BIST_PATTERN_ENGINE -- requirements
Module: bist_pattern_engine

Interface
REQ-001 SHALL have parameter PAT_W, default 4, meaning width of applied pattern (2..32).
REQ-002 SHALL have parameter RESP_W, default 4, meaning width of captured DUT response (2..32).
REQ-003 SHALL have parameter NUM_PAT, default 15, meaning patterns applied per run (1..2^16-1).
REQ-004 SHALL have parameter LFSR_TAPS, default 4'b1100, meaning PAT_W-bit feedback mask of the pattern LFSR.
REQ-005 SHALL have parameter LFSR_SEED, default 4'b0001, meaning PAT_W-bit non-zero LFSR start value.
REQ-006 SHALL have parameter MISR_TAPS, default 4'b1100, meaning RESP_W-bit feedback mask of the signature register.
REQ-007 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-008 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port start, input, 1, run request, sampled in IDLE or DONE.
REQ-010 SHALL have port mode, input, 1, 0 = pseudo-random LFSR patterns, 1 = exhaustive up-counter patterns; latched on accepted start.
REQ-011 SHALL have port golden, input, RESP_W, expected fault-free signature; compared in DONE.
REQ-012 SHALL have port pat_out, output, PAT_W, pattern driven to the circuit under test.
REQ-013 SHALL have port resp_in, input, RESP_W, combinational response of the circuit under test to pat_out.
REQ-014 SHALL have port busy, output, 1, high in RUN.
REQ-015 SHALL have port done, output, 1, high in DONE.
REQ-016 SHALL have port signature, output, RESP_W, current MISR contents.
REQ-017 SHALL have port pass, output, 1, valid when done: signature == golden.

Function
REQ-018 SHALL implement states IDLE, RUN, DONE; IDLE/DONE --start--> RUN; RUN --NUM_PAT-th capture--> DONE; no other transitions except reset.
REQ-019 On accepted start: pat_out loads LFSR_SEED (mode 0) or 0 (mode 1), signature clears to 0, pattern index clears to 0, busy high from the next cycle.
REQ-020 Each RUN cycle SHALL capture: signature <= {signature[RESP_W-2:0], ^(signature & MISR_TAPS)} ^ resp_in.
REQ-021 Each RUN cycle SHALL advance the pattern: mode 0 pat_out <= {pat_out[PAT_W-2:0], ^(pat_out & LFSR_TAPS)}; mode 1 pat_out <= pat_out + 1 modulo 2^PAT_W (wraps silently).
REQ-022 Pattern index SHALL increment per capture; capture with index == NUM_PAT-1 SHALL be the last, entering DONE next cycle; exactly NUM_PAT captures per run.
REQ-023 In DONE, pat_out and signature SHALL hold; pass SHALL be combinational compare against live golden; pass SHALL be 0 outside DONE.
REQ-024 start and mode SHALL be ignored during RUN; mode changes mid-run have no effect.
REQ-025 start asserted in DONE SHALL restart immediately (same as from IDLE), dropping done the next cycle.
REQ-026 If the LFSR reaches all-zero (illegal seed/taps), it SHALL stay zero; no recovery required.

Reset
REQ-027 On rst high at a clock edge: state IDLE, pat_out 0, signature 0, index 0, busy 0, done 0, pass 0, latched mode 0.
REQ-028 rst SHALL dominate start in the same cycle and SHALL abort a run in progress without reaching DONE.

Verification
REQ-029 Defaults, mode 0, resp_in = pat_out (buffer DUT), start 1 cycle -> pat_out sequence 0001,0010,0100,1001,0011,0110,1101,1010,0101,1011,0111,1111,1110,1100,1000, then done=1 after exactly 15 busy cycles.
REQ-030 NUM_PAT=4, mode 1, resp_in = pat_out, golden=4'b0011 -> pat_out 0,1,2,3; signature 0000,0001,0000,0011; done with pass=1.
REQ-031 Same as REQ-030 but resp_in stuck-at-0 -> signature 0000, done=1, pass=0.
REQ-032 Assert rst at 3rd RUN cycle -> next cycle IDLE, all outputs 0; fresh start reproduces REQ-030 results exactly.
REQ-033 start held high through RUN and DONE, mode toggled mid-run -> run unaffected; one DONE cycle, then automatic restart with newly latched mode.
REQ-034 PAT_W=3, mode 1, NUM_PAT=10 -> pat_out wraps 7 to 0; 10 captures, then DONE.
